// File: rtl/spu_if_pkg.sv
// Shared sizing and FSM encoding for the instruction-fetch front end.
package spu_if_pkg;

    localparam int SPU_ADDR_W = 10;
    localparam int SPU_DEPTH  = 1 << SPU_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Loads a program into an external instruction buffer, then streams dual-issue fetch pairs.
// Latency: load writes are combinational with the accepted beat; fetch address is registered PC.
// Backpressure: load_ready only in LOAD; stall freezes PC and drops both slots, branch overrides stall.
module fetch_sequencer
    import spu_if_pkg::*;
#(
    parameter int DEPTH  = SPU_DEPTH,
    parameter int ADDR_W = SPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              slot1_valid,
    output logic              slot2_valid,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE       = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   TWO       = (ADDR_W + 1)'(2);

    seq_state_t        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W:0]   len_q, len_n;
    logic              err_q, err_n;
    logic              full_exit, full_exit_n;

    // PC arithmetic is one bit wider so the end-of-program test never wraps.
    logic [ADDR_W:0] pc_w, pc_adv;
    logic            pair_ok;

    assign pc_w     = {1'b0, pc};
    assign pair_ok  = (pc_w + ONE) < len_q;
    assign pc_adv   = pc_w + (pair_ok ? TWO : ONE);
    assign rd_addr  = pc;
    assign prog_len = len_q;
    assign load_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            cnt       <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            full_exit <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cnt       <= cnt_n;
            len_q     <= len_n;
            err_q     <= err_n;
            full_exit <= full_exit_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        cnt_n       = cnt;
        len_n       = len_q;
        full_exit_n = 1'b0;
        // A source that keeps pushing right after a buffer-full exit overran the buffer.
        err_n       = err_q | (full_exit & load_valid);
        load_ready  = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = cnt;
        wr_data     = load_data;
        slot1_valid = 1'b0;
        slot2_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (load_valid) begin
                    wr_en = 1'b1;
                    cnt_n = cnt + 1'b1;
                    if (load_last || cnt == LAST_ADDR) begin
                        state_n     = ST_FETCH;
                        len_n       = {1'b0, cnt} + ONE;
                        pc_n        = '0;
                        full_exit_n = !load_last;
                    end
                end
            end
            ST_FETCH: begin
                busy        = 1'b1;
                slot1_valid = !stall;
                slot2_valid = !stall && pair_ok;
                if (br_taken) begin
                    pc_n = br_target;
                    if ({1'b0, br_target} >= len_q)
                        state_n = ST_DONE;
                end else if (!stall) begin
                    pc_n = pc_adv[ADDR_W-1:0];
                    if (pc_adv >= len_q)
                        state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (restart) begin
                    state_n = ST_FETCH;
                    pc_n    = '0;
                end else if (start) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: expected buffer writes and fetch pairs are queued as stimulus is driven.
module tb_fetch_sequencer;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic [31:0]       load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              stall = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              restart = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              slot1_valid;
    logic              slot2_valid;
    logic [ADDR_W:0]   prog_len;
    logic              busy;
    logic              done;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+31:0] wq[$];  // {addr, data}
    logic [ADDR_W:0]    fq[$];  // {rd_addr, slot2_valid}

    fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .restart(restart),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .slot1_valid(slot1_valid), .slot2_valid(slot2_valid),
        .prog_len(prog_len), .busy(busy), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push expected beats as they are driven; one beat transfers per cycle in LOAD.
    task automatic load_words(input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = last_on_end && (i == n - 1);
            wq.push_back({ADDR_W'(i), load_data});
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic push_pairs(input int first, input int len);
        for (int p = first; p < len; p += 2)
            fq.push_back({ADDR_W'(p), (p + 1 < len)});
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            step();
            n++;
        end
        chk("done_reached", done, 1);
        chk("fetch_q_empty", fq.size(), 0);
        chk("write_q_empty", wq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wq.size() == 0) chk("unexpected_write", wr_addr, '1);
                else begin
                    logic [ADDR_W+31:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", wr_addr, e[ADDR_W+31:32]);
                    chk("wr_data", wr_data, e[31:0]);
                end
            end
            if (slot1_valid) begin
                if (fq.size() == 0) chk("unexpected_fetch", rd_addr, '1);
                else begin
                    logic [ADDR_W:0] f;
                    f = fq.pop_front();
                    chk("rd_addr", rd_addr, f[ADDR_W:1]);
                    chk("slot2_valid", slot2_valid, f[0]);
                end
            end else if (slot2_valid) begin
                chk("slot2_without_slot1", slot2_valid, 0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_slots", {slot1_valid, slot2_valid}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_load_err", load_err, 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_ignores", {busy, load_ready}, 0);

        // Five-word program: pairs (0,1), (2,3), (4,-)
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_ready_in_load", load_ready, 1);
        load_words(5, 1'b1);
        push_pairs(0, 5);
        chk("prog_len_5", prog_len, 5);
        wait_done(20);
        chk("busy_in_done", busy, 0);
        chk("no_load_err", load_err, 0);

        // Restart with a three-cycle stall at PC 2
        push_pairs(0, 5);
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rd_addr", rd_addr, 2);
            chk("stall_slots", {slot1_valid, slot2_valid}, 0);
            step();
        end
        stall = 1'b0;
        wait_done(20);

        // Ten-word program, branch to 7 while stalled
        start = 1'b1;
        step();
        start = 1'b0;
        load_words(10, 1'b1);
        chk("prog_len_10", prog_len, 10);
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 7;
        @(negedge clk);
        chk("br_stall_slot1", slot1_valid, 0);
        step();
        stall    = 1'b0;
        br_taken = 1'b0;
        chk("br_rd_addr", rd_addr, 7);
        push_pairs(7, 10);
        wait_done(20);

        // Out-of-range branch ends the program, restart resumes at 0
        restart = 1'b1;
        step();
        restart   = 1'b0;
        br_taken  = 1'b1;
        br_target = 12;
        fq.push_back({ADDR_W'(0), 1'b1});
        step();
        br_taken = 1'b0;
        chk("br_oob_done", done, 1);
        chk("br_oob_busy", busy, 0);
        restart = 1'b1;
        push_pairs(0, 10);
        step();
        restart = 1'b0;
        chk("restart_rd_addr", rd_addr, 0);
        chk("restart_busy", busy, 1);
        wait_done(20);

        // Full-depth load without load_last, then one overrun beat
        start = 1'b1;
        step();
        start = 1'b0;
        stall = 1'b1;
        load_words(DEPTH, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'hdead_beef;
        @(negedge clk);
        chk("full_busy", busy, 1);
        chk("full_load_ready", load_ready, 0);
        chk("overrun_no_write", wr_en, 0);
        step();
        load_valid = 1'b0;
        chk("overrun_load_err", load_err, 1);
        chk("prog_len_full", prog_len, DEPTH);
        push_pairs(0, DEPTH);
        stall = 1'b0;
        wait_done(DEPTH);
        chk("load_err_sticky", load_err, 1);

        // Reset in the middle of a load
        start = 1'b1;
        step();
        start = 1'b0;
        load_words(3, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        rst        = 1'b1;
        #1;
        chk("midrst_load_ready", load_ready, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_prog_len", prog_len, 0);
        chk("midrst_load_err", load_err, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        step();
        rst        = 1'b0;
        load_valid = 1'b0;
        step();
        chk("post_rst_idle", {busy, load_ready}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DEPTH, default 1024, instruction buffer depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 10, buffer address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  pulse; begins a program load.
REQ-006 load_valid  input  1  load word present on load_data.
REQ-007 load_data  input  32  instruction word to store.
REQ-008 load_last  input  1  qualifies final word of the program.
REQ-009 load_ready  output  1  sequencer accepts a load word this cycle.
REQ-010 stall  input  1  decode cannot accept a fetch pair this cycle.
REQ-011 br_taken  input  1  branch redirect request.
REQ-012 br_target  input  ADDR_W  redirect word address.
REQ-013 restart  input  1  re-run the loaded program from address 0 without reload.
REQ-014 wr_en, wr_addr, wr_data  output  1/ADDR_W/32  buffer write port.
REQ-015 rd_addr  output  ADDR_W  buffer read address for slot 1; slot 2 reads rd_addr+1.
REQ-016 slot1_valid, slot2_valid  output  1/1  fetch pair qualifiers.
REQ-017 prog_len  output  ADDR_W+1  number of words loaded (1..DEPTH).
REQ-018 busy, done, load_err  output  1/1/1  status flags.

Function
REQ-019 FSM states: IDLE, LOAD, FETCH, DONE, encoded as a 2-bit state.
REQ-020 IDLE: start -> LOAD, word counter cleared to 0; all other inputs ignored.
REQ-021 LOAD: load_ready = 1; a beat transfers when load_valid and load_ready are both 1.
REQ-022 On each beat: wr_en = 1, wr_addr = counter, wr_data = load_data, combinational in the same cycle; counter increments.
REQ-023 LOAD exits to FETCH on a beat with load_last = 1, or on the beat written at address DEPTH-1; prog_len = counter+1, PC = 0.
REQ-024 A load_valid in the cycle after the DEPTH-1 beat (without load_last) SHALL set sticky load_err and SHALL NOT write.
REQ-025 FETCH: rd_addr = PC; slot1_valid = !stall; slot2_valid = !stall and (PC+1 < prog_len).
REQ-026 FETCH advance, no stall, no branch: PC += 2 if slot2_valid, else PC += 1; computed in ADDR_W+1 bits.
REQ-027 If the advanced PC >= prog_len, next state is DONE; PC SHALL NOT wrap into stale buffer words.
REQ-028 stall = 1 with br_taken = 0: PC holds, both slots 0.
REQ-029 br_taken = 1 in FETCH has priority over stall and advance: next PC = br_target; if br_target >= prog_len, go to DONE.
REQ-030 An odd br_target is legal; pairing realigns with no restriction.
REQ-031 DONE: done = 1, slots 0; restart -> FETCH with PC = 0; start -> LOAD (restart takes priority if both).
REQ-032 busy = 1 in LOAD and FETCH, else 0.
REQ-033 start, restart and br_taken outside their listed states SHALL be ignored.

Reset
REQ-034 rst SHALL force IDLE, PC = 0, counter = 0, prog_len = 0, load_err = 0.
REQ-035 During reset all outputs SHALL be 0: load_ready, wr_en, slot valids, busy, done.
REQ-036 Reset mid-LOAD or mid-FETCH SHALL abandon the operation; buffer contents are not cleared by this block.

Structure
REQ-037 DEPTH, ADDR_W and the FSM state encoding SHALL live in shared package spu_if_pkg.
REQ-038 No sub-module; the buffer memory SHALL be external, driven through the wr_*/rd_addr ports.

Verification
REQ-039 Load 5 words, last on word 4 -> wr_addr 0..4, prog_len = 5; fetch pairs (0,1), (2,3), (4, slot2 = 0); then done = 1.
REQ-040 Load 1024 words, no load_last, then one extra load_valid -> FETCH entered after beat 1023, load_err = 1, no write to address 0.
REQ-041 Fetch at PC 2 with stall = 1 for 3 cycles -> rd_addr holds 2, slots 0; resumes at 2.
REQ-042 stall = 1 and br_taken = 1, br_target = 7, prog_len = 10 -> next rd_addr = 7; then (7,8), (9, slot2 = 0), then DONE.
REQ-043 br_target = 12 with prog_len = 10 -> DONE next cycle; restart -> FETCH with rd_addr = 0.
REQ-044 rst asserted mid-LOAD at beat 3 -> IDLE immediately; load_ready = 0, prog_len = 0.
